// File: rtl/gpio_sweep_sequencer.sv
// Self-test stimulus sequencer: sweeps every {sel,sw} code onto the GPIO
// inputs, waits for a completion strobe and streams out one result record per code.
module gpio_sweep_sequencer #(
    parameter int SW_W    = 4,
    parameter int SEL_W   = 1,
    parameter int RES_W   = 32,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  dut_done,
    input  logic                  dut_err,
    input  logic [RES_W-1:0]      dut_res,
    output logic [SW_W-1:0]       stim_sw,
    output logic [SEL_W-1:0]      stim_sel,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [SW_W+SEL_W-1:0] res_idx,
    output logic [RES_W-1:0]      res_data,
    output logic                  res_err,
    output logic                  res_tmo,
    output logic                  busy,
    output logic                  finished,
    output logic [CNT_W-1:0]      err_cnt,
    output logic [CNT_W-1:0]      tmo_cnt
);

    localparam int IW  = SW_W + SEL_W;
    localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int TCW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_WAIT,
        S_REPORT,
        S_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [IW-1:0]      stim_q, stim_d;
    logic [SCW-1:0]     scnt_q, scnt_d;
    logic [TCW-1:0]     wcnt_q, wcnt_d;
    logic               rvalid_q, rvalid_d;
    logic [RES_W-1:0]   rdata_q, rdata_d;
    logic               rerr_q, rerr_d;
    logic               rtmo_q, rtmo_d;
    logic               busy_q, busy_d;
    logic               fin_q, fin_d;
    logic [CNT_W-1:0]   errc_q, errc_d;
    logic [CNT_W-1:0]   tmoc_q, tmoc_d;

    // Next-state and next-output logic; abort overrides every transition.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        stim_d   = stim_q;
        scnt_d   = scnt_q;
        wcnt_d   = wcnt_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rerr_d   = rerr_q;
        rtmo_d   = rtmo_q;
        busy_d   = busy_q;
        fin_d    = fin_q;
        errc_d   = errc_q;
        tmoc_d   = tmoc_q;
        if (abort) begin
            state_d  = S_IDLE;
            stim_d   = '0;
            rvalid_d = 1'b0;
            busy_d   = 1'b0;
            fin_d    = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_FINISH: begin
                    if (start) begin
                        state_d = S_SETTLE;
                        idx_d   = '0;
                        stim_d  = '0;
                        scnt_d  = '0;
                        errc_d  = '0;
                        tmoc_d  = '0;
                        fin_d   = 1'b0;
                        busy_d  = 1'b1;
                    end
                end
                S_SETTLE: begin
                    // done seen here belongs to the previous code
                    if (scnt_q == SCW'(SETTLE - 1)) begin
                        state_d = S_WAIT;
                        wcnt_d  = '0;
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (dut_done) begin
                        state_d  = S_REPORT;
                        rdata_d  = dut_res;
                        rerr_d   = dut_err;
                        rtmo_d   = 1'b0;
                        rvalid_d = 1'b1;
                    end else if (wcnt_q == TCW'(TIMEOUT - 1)) begin
                        state_d  = S_REPORT;
                        rdata_d  = '0;
                        rerr_d   = 1'b0;
                        rtmo_d   = 1'b1;
                        rvalid_d = 1'b1;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
                S_REPORT: begin
                    if (res_ready) begin
                        rvalid_d = 1'b0;
                        if (rerr_q && (errc_q != '1)) begin
                            errc_d = errc_q + 1'b1;
                        end
                        if (rtmo_q && (tmoc_q != '1)) begin
                            tmoc_d = tmoc_q + 1'b1;
                        end
                        if (idx_q == '1) begin
                            state_d = S_FINISH;
                            busy_d  = 1'b0;
                            fin_d   = 1'b1;
                        end else begin
                            state_d = S_SETTLE;
                            idx_d   = idx_q + 1'b1;
                            stim_d  = idx_q + 1'b1;
                            scnt_d  = '0;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and registered outputs, cleared asynchronously by rst low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            stim_q   <= '0;
            scnt_q   <= '0;
            wcnt_q   <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rerr_q   <= 1'b0;
            rtmo_q   <= 1'b0;
            busy_q   <= 1'b0;
            fin_q    <= 1'b0;
            errc_q   <= '0;
            tmoc_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            stim_q   <= stim_d;
            scnt_q   <= scnt_d;
            wcnt_q   <= wcnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rerr_q   <= rerr_d;
            rtmo_q   <= rtmo_d;
            busy_q   <= busy_d;
            fin_q    <= fin_d;
            errc_q   <= errc_d;
            tmoc_q   <= tmoc_d;
        end
    end

    assign stim_sw   = stim_q[SW_W-1:0];
    assign stim_sel  = stim_q[IW-1:SW_W];
    assign res_valid = rvalid_q;
    assign res_idx   = idx_q;
    assign res_data  = rdata_q;
    assign res_err   = rerr_q;
    assign res_tmo   = rtmo_q;
    assign busy      = busy_q;
    assign finished  = fin_q;
    assign err_cnt   = errc_q;
    assign tmo_cnt   = tmoc_q;

endmodule

// File: tb/tb_gpio_sweep_sequencer.sv
// Bench for gpio_sweep_sequencer: a behavioural SoC responder plus a
// record scoreboard, driven by a table of sweep scenarios and a few hand sequences.
module tb_gpio_sweep_sequencer;

    localparam int SW_W = 4;
    localparam int SEL_W = 1;
    localparam int IW = SW_W + SEL_W;
    localparam int RES_W = 32;
    localparam int TMO = 64;
    localparam int NVEC = 1 << IW;

    logic clk = 1'b0;
    logic rst, start, abort;
    logic dut_done, dut_err, res_ready;
    logic [RES_W-1:0] dut_res;
    logic [SW_W-1:0] stim_sw;
    logic [SEL_W-1:0] stim_sel;
    logic res_valid, res_err, res_tmo, busy, finished;
    logic [IW-1:0] res_idx;
    logic [RES_W-1:0] res_data;
    logic [15:0] err_cnt, tmo_cnt;

    always #5 clk = ~clk;

    gpio_sweep_sequencer #(
        .SW_W(SW_W), .SEL_W(SEL_W), .RES_W(RES_W),
        .SETTLE(2), .TIMEOUT(TMO), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .dut_done(dut_done), .dut_err(dut_err), .dut_res(dut_res),
        .stim_sw(stim_sw), .stim_sel(stim_sel),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_idx(res_idx), .res_data(res_data),
        .res_err(res_err), .res_tmo(res_tmo),
        .busy(busy), .finished(finished),
        .err_cnt(err_cnt), .tmo_cnt(tmo_cnt)
    );

    typedef struct {
        bit err_mode;
        int tmo_idx;
        int pulse_idx;
        int stall_idx;
        int exp_err;
        int exp_tmo;
    } vec_t;

    typedef struct {
        int idx;
        logic [RES_W-1:0] data;
        logic err;
        logic tmo;
        int lat;
    } rec_t;

    int checks = 0;
    int failures = 0;

    bit err_mode;
    int tmo_idx, pulse_idx, stall_idx, stall_left;
    bit mon_en;
    int m_idx, m_err, m_tmo, rec_n;
    int age;
    logic busy_p, valid_p;
    logic [IW-1:0] cur, cur_p;
    rec_t q[$];
    rec_t e;
    bit nd;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [RES_W-1:0] res_fn(int i);
        return 32'hA5A5_0000 ^ (i * 32'h0001_0203);
    endfunction

    // SoC responder and record scoreboard, both acting on the falling edge
    always @(negedge clk) begin
        cur = {stim_sel, stim_sw};
        if (!rst) begin
            age = 0;
            busy_p = 1'b0;
            valid_p = 1'b0;
            cur_p = '0;
            dut_done = 1'b0;
            dut_err = 1'b0;
            dut_res = '0;
            res_ready = 1'b1;
        end else begin
            if (busy && (!busy_p || cur != cur_p)) begin
                age = 0;
                if (mon_en) begin
                    chk("stim_idx", 64'(cur), 64'(m_idx));
                    nd = (m_idx == tmo_idx) || (m_idx == pulse_idx);
                    e.idx = m_idx;
                    e.tmo = nd;
                    e.data = nd ? '0 : res_fn(m_idx);
                    e.err = !nd && err_mode && ((m_idx % 16) > 12);
                    e.lat = nd ? 2 + TMO : 5;
                    q.push_back(e);
                end
            end else if (age < 100000) begin
                age++;
            end
            busy_p = busy;
            cur_p = cur;
            dut_done = busy &&
                ((age == 4 && int'(cur) != tmo_idx && int'(cur) != pulse_idx) ||
                 (age == 1 && int'(cur) == pulse_idx));
            dut_err = err_mode && (stim_sw > 4'd12);
            dut_res = res_fn(int'(cur));
            if (mon_en && res_valid) begin
                if (q.size() == 0) begin
                    chk("q_empty", 64'(res_idx), 64'hFFFF);
                    res_ready = 1'b1;
                end else begin
                    e = q[0];
                    if (!valid_p) chk("latency", 64'(age), 64'(e.lat));
                    chk("res_idx", 64'(res_idx), 64'(e.idx));
                    chk("res_data", 64'(res_data), 64'(e.data));
                    chk("res_err", 64'(res_err), 64'(e.err));
                    chk("res_tmo", 64'(res_tmo), 64'(e.tmo));
                    chk("err_cnt_run", 64'(err_cnt), 64'(m_err));
                    chk("tmo_cnt_run", 64'(tmo_cnt), 64'(m_tmo));
                    if (e.idx == stall_idx && stall_left > 0) begin
                        res_ready = 1'b0;
                        stall_left--;
                    end else begin
                        res_ready = 1'b1;
                        void'(q.pop_front());
                        m_idx++;
                        rec_n++;
                        if (e.err) m_err++;
                        if (e.tmo) m_tmo++;
                    end
                end
            end
            valid_p = res_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic model_clear();
        q.delete();
        m_idx = 0;
        m_err = 0;
        m_tmo = 0;
        rec_n = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, "_valid"}, 64'(res_valid), 0);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_fin"}, 64'(finished), 0);
        chk({tag, "_errc"}, 64'(err_cnt), 0);
        chk({tag, "_tmoc"}, 64'(tmo_cnt), 0);
        chk({tag, "_stim"}, 64'({stim_sel, stim_sw}), 0);
        chk({tag, "_idx"}, 64'(res_idx), 0);
        chk({tag, "_data"}, 64'(res_data), 0);
        chk({tag, "_err"}, 64'(res_err), 0);
        chk({tag, "_tmo"}, 64'(res_tmo), 0);
    endtask

    vec_t tbl[5];

    initial begin
        bit hit;
        tbl[0] = '{0, -1, -1, 3, 0, 0};
        tbl[1] = '{1, -1, -1, -1, 6, 0};
        tbl[2] = '{0, 7, -1, -1, 0, 1};
        tbl[3] = '{0, -1, 9, -1, 0, 1};
        tbl[4] = '{1, 29, -1, -1, 5, 1};

        rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        mon_en = 1'b0;
        err_mode = 1'b0;
        tmo_idx = -1;
        pulse_idx = -1;
        stall_idx = -1;
        stall_left = 0;
        model_clear();
        #1;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        tick();
        check_all_zero("idle");

        for (int i = 0; i < 5; i++) begin
            err_mode = tbl[i].err_mode;
            tmo_idx = tbl[i].tmo_idx;
            pulse_idx = tbl[i].pulse_idx;
            stall_idx = tbl[i].stall_idx;
            stall_left = 10;
            model_clear();
            mon_en = 1'b1;
            pulse_start();
            chk("start_busy", 64'(busy), 1);
            chk("start_fin", 64'(finished), 0);
            chk("start_errc", 64'(err_cnt), 0);
            chk("start_tmoc", 64'(tmo_cnt), 0);
            repeat (40) tick();
            pulse_start();
            hit = 1'b0;
            for (int c = 0; c < 4000; c++) begin
                tick();
                if (finished) begin
                    hit = 1'b1;
                    break;
                end
            end
            chk("finish_reached", 64'(hit), 1);
            chk("fin_busy", 64'(busy), 0);
            chk("fin_valid", 64'(res_valid), 0);
            chk("fin_errc", 64'(err_cnt), 64'(tbl[i].exp_err));
            chk("fin_tmoc", 64'(tmo_cnt), 64'(tbl[i].exp_tmo));
            chk("fin_records", 64'(rec_n), 64'(NVEC));
            chk("fin_stim", 64'({stim_sel, stim_sw}), 64'(NVEC - 1));
            chk("fin_queue", 64'(q.size()), 0);
            repeat (3) tick();
            chk("fin_hold_errc", 64'(err_cnt), 64'(tbl[i].exp_err));
        end

        err_mode = 1'b1;
        tmo_idx = -1;
        pulse_idx = -1;
        stall_idx = -1;
        model_clear();
        mon_en = 1'b1;
        pulse_start();
        hit = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            tick();
            if (res_valid && m_idx == 14) begin
                hit = 1'b1;
                break;
            end
        end
        chk("abort_reach", 64'(hit), 1);
        mon_en = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", 64'(res_valid), 0);
        chk("abort_busy", 64'(busy), 0);
        chk("abort_fin", 64'(finished), 0);
        chk("abort_stim", 64'({stim_sel, stim_sw}), 0);
        chk("abort_errc", 64'(err_cnt), 1);
        chk("abort_tmoc", 64'(tmo_cnt), 0);
        repeat (3) tick();
        chk("abort_hold_errc", 64'(err_cnt), 1);
        chk("abort_hold_busy", 64'(busy), 0);

        model_clear();
        mon_en = 1'b1;
        pulse_start();
        chk("restart_errc", 64'(err_cnt), 0);
        chk("restart_busy", 64'(busy), 1);
        chk("restart_stim", 64'({stim_sel, stim_sw}), 0);
        hit = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            tick();
            if (m_idx == 16 && busy && age == 2) begin
                hit = 1'b1;
                break;
            end
        end
        chk("rst_reach", 64'(hit), 1);
        chk("pre_rst_errc", 64'(err_cnt), 3);
        mon_en = 1'b0;
        rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
